// File: rtl/nibble_serial_subtractor_8bit.sv
// nibble_serial_subtractor_8bit: multi-cycle 8-bit a - b - bin using one shared
// 4-bit subtract datapath, low nibble first, then high nibble with chained borrow.
// Valid/ready handshakes on both the operand and result sides.
// Optional build macro SUB_SATURATE_EN: on signed overflow, diff saturates to
// 0x7F (a[7]=0) or 0x80 (a[7]=1); bout and ovf still report the raw result.
module nibble_serial_subtractor_8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       bin,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] diff,
  output logic       bout,
  output logic       ovf
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLo   = 2'd1;
  localparam logic [1:0] StHi   = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0] state_q, state_d;
  logic [7:0] a_q, b_q;
  logic       bin_q;
  logic       br_q;
  logic [7:0] diff_q;
  logic       bout_q;
  logic       ovf_q;

  logic [3:0] op_a, op_b;
  logic       op_bin;
  logic [4:0] sub;
  logic       ovf_raw;
  logic [7:0] hi_diff;

  // Shared nibble datapath: operand select follows the current pass.
  always_comb begin
    op_a   = a_q[3:0];
    op_b   = b_q[3:0];
    op_bin = bin_q;
    if (state_q == StHi) begin
      op_a   = a_q[7:4];
      op_b   = b_q[7:4];
      op_bin = br_q;
    end
    // Bit 4 of the 5-bit difference is the borrow out of this nibble.
    sub = {1'b0, op_a} - {1'b0, op_b} - {4'b0000, op_bin};
  end

  // High-pass result assembly, overflow detect and optional saturation.
  always_comb begin
    // Sign of the raw result is the top bit of the high-nibble difference.
    ovf_raw = (a_q[7] != b_q[7]) && (sub[3] != a_q[7]);
    hi_diff = {sub[3:0], diff_q[3:0]};
`ifdef SUB_SATURATE_EN
    if (ovf_raw) begin
      hi_diff = a_q[7] ? 8'h80 : 8'h7F;
    end
`endif
  end

  // Next-state logic for the IDLE -> LO -> HI -> DONE sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (in_valid) state_d = StLo;
      StLo:    state_d = StHi;
      StHi:    state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, operand capture and per-pass result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      bin_q   <= 1'b0;
      br_q    <= 1'b0;
      diff_q  <= 8'h00;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            bin_q <= bin;
          end
        end
        StLo: begin
          diff_q[3:0] <= sub[3:0];
          br_q        <= sub[4];
        end
        StHi: begin
          diff_q <= hi_diff;
          bout_q <= sub[4];
          ovf_q  <= ovf_raw;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_subtractor_8bit.sv
// Bench for nibble_serial_subtractor_8bit: directed vectors with literal
// expectations, plus a scoreboard fed by an arithmetic model of a - b - bin.
// Build with +define+SUB_SATURATE_EN to check the saturating variant.
module tb_nibble_serial_subtractor_8bit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected {ovf, bout, diff} for each accepted operation, oldest first.
  logic [9:0] exp_q[$];

`ifdef SUB_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  nibble_serial_subtractor_8bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Plain integer arithmetic; overflow rule is the sign-mismatch test on raw result.
  function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                       input logic mbin);
    int         full;
    logic [7:0] raw;
    logic [7:0] d;
    logic       bo;
    logic       ov;
    full = int'(ma) - int'(mb) - int'(mbin);
    raw  = 8'(full);
    bo   = (full < 0);
    ov   = (ma[7] != mb[7]) && (raw[7] != ma[7]);
    d    = raw;
    if (Sat && ov) d = ma[7] ? 8'h80 : 8'h7F;
    return {ov, bo, d};
  endfunction

  // Scoreboard: inputs are stable at the falling edge, so handshakes seen here
  // are the ones the next rising edge will commit.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("sb_spurious_valid", 32'(out_valid), 32'd0);
        end else begin
          chk("sb_diff", 32'(diff), 32'(exp_q[0][7:0]));
          chk("sb_bout", 32'(bout), 32'(exp_q[0][8]));
          chk("sb_ovf", 32'(ovf), 32'(exp_q[0][9]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, bin));
    end
  end

  // One full operation with out_ready held high; checks cycle-exact timing
  // and the hand-computed result. Entered and left at posedge+1 in IDLE.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                        input logic [7:0] ed, input logic eb, input logic eo);
    chk("pre_in_ready", 32'(in_ready), 32'd1);
    a = ta; b = tb_; bin = tbin; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;  // E0
    in_valid = 1'b0; a = ~ta; b = ~tb_; bin = ~tbin;
    chk("e0_in_ready", 32'(in_ready), 32'd0);
    chk("e0_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;  // E1
    chk("e1_in_ready", 32'(in_ready), 32'd0);
    chk("e1_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;  // E2
    chk("e2_out_valid", 32'(out_valid), 32'd1);
    chk("e2_in_ready", 32'(in_ready), 32'd0);
    chk("lit_diff", 32'(diff), 32'(ed));
    chk("lit_bout", 32'(bout), 32'(eb));
    chk("lit_ovf", 32'(ovf), 32'(eo));
    @(posedge clk); #1;  // E3
    chk("e3_out_valid", 32'(out_valid), 32'd0);
    chk("e3_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = 8'h00; b = 8'h00; bin = 1'b0;
    #1;
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic, inter-nibble borrow, equal operands with borrow in.
    run_op(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);
    run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
    run_op(8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0);
    // Wrap-around boundaries.
    run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_op(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0);
    // Signed overflow in both directions.
    run_op(8'h80, 8'h01, 1'b0, Sat ? 8'h80 : 8'h7F, 1'b0, 1'b1);
    run_op(8'h7F, 8'hFF, 1'b0, Sat ? 8'h7F : 8'h80, 1'b1, 1'b1);

    // Backpressure: hold result while new operands are offered.
    a = 8'h44; b = 8'h11; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bp_valid_start", 32'(out_valid), 32'd1);
    a = 8'hAA; b = 8'h55; bin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_diff", 32'(diff), 32'h33);
      chk("bp_bout", 32'(bout), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bp_new_valid", 32'(out_valid), 32'd1);
    chk("bp_new_diff", 32'(diff), Sat ? 32'h80 : 32'h55);
    chk("bp_new_bout", 32'(bout), 32'd0);
    chk("bp_new_ovf", 32'(ovf), 32'd1);
    @(posedge clk); #1;
    chk("bp_done", 32'(out_valid), 32'd0);

    // Asynchronous reset while the high nibble is in flight.
    a = 8'h77; b = 8'h22; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;  // E0 -> LO
    in_valid = 1'b0;
    @(posedge clk); #2;  // E1 -> HI
    rst = 1'b1;
    #1;
    chk("arst_diff", 32'(diff), 32'd0);
    chk("arst_bout", 32'(bout), 32'd0);
    chk("arst_ovf", 32'(ovf), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("arst_no_valid", 32'(out_valid), 32'd0);
    end
    run_op(8'h09, 8'h03, 1'b0, 8'h06, 1'b0, 1'b0);

    @(posedge clk); #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nibble_serial_subtractor_8bit.md
Name: nibble_serial_subtractor_8bit

Overview:
Multi-cycle 8-bit subtractor computing a - b - bin with one shared 4-bit subtract datapath, applied low nibble then high nibble. The borrow chains between the two passes. It is the subtract counterpart of the two-nibble 8-bit adder. Valid/ready handshakes on both sides let it sit between registered pipeline stages in ALU-style datapaths.

Parameters:
none (width fixed at 8 bits, nibble width fixed at 4)

Ports:
clk        input   1  rising-edge clock
rst        input   1  asynchronous reset, active-high
in_valid   input   1  operands a, b, bin valid
in_ready   output  1  block can accept operands
a          input   8  minuend
b          input   8  subtrahend
bin        input   1  borrow in
out_valid  output  1  result valid
out_ready  input   1  consumer accepts result
diff       output  8  a - b - bin, modulo 256 (saturated if the optional feature is enabled)
bout       output  1  unsigned borrow out: 1 when a < b + bin
ovf        output  1  signed (two's complement) overflow

Behaviour:
- Reset (async, rst=1):
  - state=IDLE
  - diff=0x00, bout=0, ovf=0, out_valid=0
  - internal operand and borrow registers = 0
  - in_ready=1 once state is IDLE
- States: IDLE, LO, HI, DONE. All transitions occur on the rising edge of clk.
- IDLE:
  - in_ready=1.
  - On in_valid=1: latch a, b, bin; go to LO.
  - Inputs are not sampled in any other state.
- LO:
  - Compute {br, d} = {1'b0,a[3:0]} - {1'b0,b[3:0]} - bin as a 5-bit difference.
  - Store diff[3:0]=d and br as the internal borrow (br = bit 4 of the result).
  - Go to HI.
- HI:
  - Same operation on a[7:4], b[7:4], with borrow in = stored br.
  - Store diff[7:4] and bout.
  - Compute ovf = (a[7] != b[7]) && (raw_diff[7] != a[7]), where raw_diff is the unsaturated result.
  - Go to DONE.
- DONE:
  - out_valid=1.
  - diff, bout and ovf are held stable while out_ready=0.
  - When out_ready=1: go to IDLE, out_valid drops next cycle.
- Latency and throughput:
  - Accept edge E0; out_valid is high after edge E2.
  - With out_ready tied 1, in_ready returns after E3; the next accept is at E4.
  - Throughput: one operation per 4 cycles.
- in_ready = (state==IDLE), purely combinational from state. Operand changes after acceptance have no effect.
- Outputs diff, bout, ovf keep the last result after leaving DONE until overwritten by the next LO/HI pass. Consumers qualify with out_valid.
- Boundaries:
  - 0x00-0xFF-1 wraps to 0x00 with bout=1.
  - bin=1 with a==b gives 0xFF, bout=1, ovf=0.
- Reset mid-operation (any state): immediate return to IDLE with all outputs zeroed. The in-flight operation is discarded with no partial result.

Optional Feature:
- Macro: SUB_SATURATE_EN
- Defined: when ovf=1, diff is forced to 0x7F if a[7]=0, or to 0x80 if a[7]=1. bout and ovf still reflect the raw computation. Saturation is applied at the HI→DONE edge; latency is unchanged.
- Not defined: diff is always the modulo-256 result; no saturation logic is present.

Test Plan:
1. a=0x35, b=0x12, bin=0, out_ready=1 → diff=0x23, bout=0, ovf=0. out_valid exactly 2 cycles after the accept edge, high for 1 cycle; in_ready=0 from E0 to E3.
2. a=0x10, b=0x01, bin=0 → diff=0x0F, bout=0, ovf=0 (inter-nibble borrow). Then a=0x05, b=0x05, bin=1 → diff=0xFF, bout=1, ovf=0.
3. a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1, ovf=0. Then a=0x00, b=0xFF, bin=1 → diff=0x00, bout=1, ovf=0.
4. a=0x80, b=0x01 → ovf=1, bout=0, diff=0x7F (SUB_SATURATE_EN: 0x80). Then a=0x7F, b=0xFF, bin=0 → ovf=1, bout=1, diff=0x80 (SUB_SATURATE_EN: 0x7F).
5. Backpressure:
   - Stimulus: result pending, out_ready=0 for 5 cycles while in_valid=1 with new operands a=0xAA, b=0x55.
   - Required: out_valid, diff and bout held; in_ready=0; new operands ignored.
   - Then out_ready=1 for 1 cycle → IDLE, after which 0xAA-0x55 is accepted → diff=0x55.
6. Assert rst asynchronously while in HI:
   - Outputs zero immediately, without waiting for a clock edge; in_ready=1 after rst deasserts.
   - No out_valid pulse for the aborted operation.
   - The next operation a=0x09, b=0x03 → diff=0x06.
